// File: rtl/dr_mem_pkg.sv
// Shared types for the data-register memory port: FSM states, data and wait-counter widths.
// No logic; pure declarations plus a parity helper.
// No flow control.
package dr_mem_pkg;
  localparam int DATA_W = 16;
  localparam int WCNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_ACCESS = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  function automatic logic even_par(input logic [DATA_W-1:0] d);
    return ^d;
  endfunction
endpackage

// File: rtl/dr_mem_array.sv
// Word storage for dr_mem_port: synchronous write, registered read.
// Latency: one edge from re to rdata; rdata holds until the next re.
// No backpressure; the owning FSM guarantees one access per transaction.
module dr_mem_array #(
  parameter int ADDR_W = 12,
  parameter int WORD_W = 16
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);
  logic [WORD_W-1:0] mem [2**ADDR_W];

  // Contents survive reset; only the read register is cleared.
  always_ff @(posedge CLK) begin
    if (we) mem[addr] <= wdata;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)  rdata <= '0;
    else if (re) rdata <= mem[addr];
  end
endmodule

// File: rtl/dr_mem_port.sv
// Memory port feeding the data register: IDLE -> WAIT x WAIT_CYCLES -> ACCESS -> DONE. DR_MEM_PARITY_EN adds parity.
// Latency: done in the cycle after edge k+WAIT_CYCLES+1 for a request sampled at edge k.
// No backpressure; requests outside IDLE are dropped, busy tells the requester when to retry.
module dr_mem_port
  import dr_mem_pkg::*;
#(
  parameter int ADDR_W      = 12,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              memRD,
  input  logic              memWR,
  input  logic [ADDR_W-1:0] memADDR,
  input  logic [DATA_W-1:0] DR,
  input  logic              parINJ,
  output logic [DATA_W-1:0] inDR,
  output logic              drLD,
  output logic              busy,
  output logic              done,
  output logic              parERR
);
  localparam logic [WCNT_W-1:0] WAIT_LD = WCNT_W'(WAIT_CYCLES);

  state_t              state, nxt;
  logic [WCNT_W-1:0]   wcnt;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   data_q;
  logic                wr_q;
  logic                accept;
  logic                we, re;

  assign accept = (state == ST_IDLE) && (memRD || memWR);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= ST_IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      ST_IDLE:   if (accept) nxt = (WAIT_CYCLES == 0) ? ST_ACCESS : ST_WAIT;
      ST_WAIT:   if (wcnt == WCNT_W'(1)) nxt = ST_ACCESS;
      ST_ACCESS: nxt = ST_DONE;
      ST_DONE:   nxt = ST_IDLE;
      default:   nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = (state != ST_IDLE);
    done = (state == ST_DONE);
    drLD = (state == ST_DONE) && !wr_q;
    we   = (state == ST_ACCESS) && wr_q;
    re   = (state == ST_ACCESS) && !wr_q;
  end

  // A simultaneous read+write request is a write.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wcnt   <= '0;
      addr_q <= '0;
      data_q <= '0;
      wr_q   <= 1'b0;
    end else if (accept) begin
      wcnt   <= WAIT_LD;
      addr_q <= memADDR;
      data_q <= DR;
      wr_q   <= memWR;
    end else if (state == ST_WAIT) begin
      wcnt   <= wcnt - WCNT_W'(1);
    end
  end

`ifdef DR_MEM_PARITY_EN
  localparam int WORD_W = DATA_W + 1;
  logic              inj_q;
  logic              perr_q;
  logic              par_bad;
  logic [WORD_W-1:0] rdata;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)      inj_q <= 1'b0;
    else if (accept) inj_q <= parINJ;
  end

  // Flag is visible during DONE and latched on its exit edge.
  assign par_bad = drLD && (^rdata);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)       perr_q <= 1'b0;
    else if (par_bad) perr_q <= 1'b1;
  end

  assign parERR = perr_q | par_bad;

  dr_mem_array #(.ADDR_W(ADDR_W), .WORD_W(WORD_W)) u_array (
    .CLK   (CLK),
    .RST_N (RST_N),
    .we    (we),
    .re    (re),
    .addr  (addr_q),
    .wdata ({even_par(data_q) ^ inj_q, data_q}),
    .rdata (rdata)
  );
`else
  localparam int WORD_W = DATA_W;
  logic              unused_parinj;
  logic [WORD_W-1:0] rdata;

  assign unused_parinj = parINJ;
  assign parERR        = 1'b0;

  dr_mem_array #(.ADDR_W(ADDR_W), .WORD_W(WORD_W)) u_array (
    .CLK   (CLK),
    .RST_N (RST_N),
    .we    (we),
    .re    (re),
    .addr  (addr_q),
    .wdata (data_q),
    .rdata (rdata)
  );
`endif

  assign inDR = rdata[DATA_W-1:0];
endmodule

// File: tb/tb_dr_mem_port.sv
// Bench for dr_mem_port: directed scenarios plus random traffic against an address-indexed memory model.
// Second instance with WAIT_CYCLES=0 covers the minimum-latency path.
module tb_dr_mem_port;
  localparam int WC = 1;
`ifdef DR_MEM_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        memRD, memWR, parINJ;
  logic [11:0] memADDR;
  logic [15:0] DR;
  logic [15:0] inDR;
  logic        drLD, busy, done, parERR;

  logic        rd0, wr0;
  logic [11:0] addr0;
  logic [15:0] dr0, indr0;
  logic        drld0, busy0, done0, perr0;

  int checks = 0;
  int errors = 0;

  logic [15:0] mdata [int];
  bit          minj  [int];
  logic [15:0] exp_indr;
  logic        exp_perr;

  always #5 CLK = ~CLK;

  dr_mem_port #(.ADDR_W(12), .WAIT_CYCLES(WC)) u_dut (
    .CLK(CLK), .RST_N(RST_N), .memRD(memRD), .memWR(memWR), .memADDR(memADDR),
    .DR(DR), .parINJ(parINJ), .inDR(inDR), .drLD(drLD), .busy(busy),
    .done(done), .parERR(parERR)
  );

  dr_mem_port #(.ADDR_W(12), .WAIT_CYCLES(0)) u_dut0 (
    .CLK(CLK), .RST_N(RST_N), .memRD(rd0), .memWR(wr0), .memADDR(addr0),
    .DR(dr0), .parINJ(1'b0), .inDR(indr0), .drLD(drld0), .busy(busy0),
    .done(done0), .parERR(perr0)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_outputs(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_drLD"}, drLD, 0);
    chk({tag, "_inDR"}, inDR, exp_indr);
    chk({tag, "_parERR"}, parERR, exp_perr);
  endtask

  // One transaction on u_dut; poke drives stray requests during WAIT and DONE.
  task automatic op(input logic wr, input logic rd, input logic [11:0] a,
                    input logic [15:0] d, input logic inj, input logic poke);
    logic is_w;
    is_w    = wr;
    memWR   = wr; memRD = rd; memADDR = a; DR = d; parINJ = inj;
    tick();
    memWR   = 1'b0; memRD = 1'b0; parINJ = 1'b0;
    memADDR = 12'($urandom); DR = 16'($urandom);
    for (int i = 0; i <= WC; i++) begin
      chk("pre_busy", busy, 1);
      chk("pre_done", done, 0);
      if (poke && i == 0) memRD = 1'b1;
      tick();
      memRD = 1'b0;
    end
    if (is_w) begin
      mdata[int'(a)] = d;
      minj[int'(a)]  = inj;
    end else begin
      exp_indr = mdata[int'(a)];
      if (PAR && minj[int'(a)]) exp_perr = 1'b1;
    end
    chk("done_pulse", done, 1);
    chk("done_busy", busy, 1);
    chk("done_drLD", drLD, !is_w);
    chk("done_inDR", inDR, exp_indr);
    chk("done_parERR", parERR, exp_perr);
    if (poke) begin
      memWR = 1'b1; memADDR = a; DR = ~d;
    end
    tick();
    memWR = 1'b0;
    idle_outputs("after");
  endtask

  initial begin
    RST_N = 1'b0; memRD = 0; memWR = 0; memADDR = 0; DR = 0; parINJ = 0;
    rd0 = 0; wr0 = 0; addr0 = 0; dr0 = 0;
    exp_indr = 16'h0000; exp_perr = 1'b0;
    repeat (3) tick();
    idle_outputs("reset");
    RST_N = 1'b1;
    tick();

    // Write then read back, including latency and drLD.
    op(1, 0, 12'h010, 16'hA5C3, 0, 0);
    op(0, 1, 12'h010, 16'h0000, 0, 0);
    chk("rd010_inDR", inDR, 16'hA5C3);

    // Read+write together is a write.
    op(1, 1, 12'hFFF, 16'h1234, 0, 0);
    op(0, 1, 12'hFFF, 16'h0000, 0, 0);
    chk("rdFFF_inDR", inDR, 16'h1234);

    // Stray requests during WAIT and DONE are ignored.
    op(0, 1, 12'h010, 16'h0000, 0, 1);
    chk("poke_idle_busy", busy, 0);
    op(0, 1, 12'h010, 16'h0000, 0, 0);
    chk("poke_nowrite", inDR, 16'hA5C3);

    // Reset during WAIT aborts a write.
    op(1, 0, 12'h020, 16'h0001, 0, 0);
    op(0, 1, 12'h020, 16'h0000, 0, 0);
    memWR = 1'b1; memADDR = 12'h020; DR = 16'hBEEF;
    tick();
    memWR = 1'b0;
    chk("wait_busy", busy, 1);
    RST_N = 1'b0;
    #1;
    exp_indr = 16'h0000; exp_perr = 1'b0;
    idle_outputs("midrst");
    tick();
    RST_N = 1'b1;
    tick();
    op(0, 1, 12'h020, 16'h0000, 0, 0);
    chk("abort_inDR", inDR, 16'h0001);

    // Random traffic, clean parity.
    for (int n = 0; n < 40; n++) begin
      logic [11:0] a;
      logic        w;
      a = 12'($urandom_range(0, 15) * 255);
      w = ($urandom_range(0, 1) == 1) || !mdata.exists(int'(a));
      op(w, (!w) || ($urandom_range(0, 3) == 0), a, 16'($urandom), 0, $urandom_range(0, 3) == 0);
    end
    chk("clean_parERR", parERR, 0);

    // Injected parity error is flagged from DONE on and is sticky.
    op(1, 0, 12'h0AB, 16'h0F0F, 1, 0);
    op(0, 1, 12'h0AB, 16'h0000, 0, 0);
    op(0, 1, 12'h010, 16'h0000, 0, 0);
    chk("sticky_parERR", parERR, PAR);

    // Zero wait states: busy exactly ACCESS + DONE.
    for (int t = 0; t < 2; t++) begin
      wr0 = (t == 0); rd0 = (t == 1); addr0 = 12'h003; dr0 = 16'h5A5A;
      tick();
      wr0 = 0; rd0 = 0; dr0 = 16'hFFFF;
      chk("w0_busy1", busy0, 1);
      chk("w0_done1", done0, 0);
      tick();
      chk("w0_busy2", busy0, 1);
      chk("w0_done2", done0, 1);
      chk("w0_drLD", drld0, t == 1);
      tick();
      chk("w0_busy3", busy0, 0);
      chk("w0_done3", done0, 0);
    end
    chk("w0_inDR", indr0, 16'h5A5A);
    chk("w0_parERR", perr0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
